// File: rtl/ge_pkg.sv
// Shared definitions for the GF(2) systolic Gaussian-elimination array:
// cell opcodes, array modes, the row feeder state encoding and skew-line
// bundle layout.
package ge_pkg;

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_SWAP = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_NOP  = 2'b11;

   localparam logic MODE_TRI = 1'b0;
   localparam logic MODE_SYS = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      FLUSH  = 2'd3
   } feed_state_t;

   // Each skew line carries {data, start, swap} for one column.
   localparam int SKEW_W     = 3;
   localparam int SKEW_DATA  = 2;
   localparam int SKEW_START = 1;
   localparam int SKEW_SWAP  = 0;

   // Index width for a memory of the given depth, never narrower than one bit.
   function automatic int index_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ge_skew_line.sv
// Fixed-length delay line for one array column. DEPTH registered stages of
// the {data, start, swap} bundle; DEPTH=0 degenerates to a plain wire so
// column 0 sees the feeder output in the same cycle.
module ge_skew_line
   import ge_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [SKEW_W-1:0] head,
   output logic [SKEW_W-1:0] tail
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_b;
      assign tail = head;
   end else begin : g_regs
      logic [SKEW_W-1:0] stages [DEPTH];

      // Shift the bundle one stage per cycle; clearing on reset drains any skewed frame.
      always_ff @(posedge clk or negedge rst_b) begin
         if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
               stages[i] <= '0;
            end
         end else begin
            stages[0] <= head;
            for (int i = 1; i < DEPTH; i++) begin
               stages[i] <= stages[i-1];
            end
         end
      end

      assign tail = stages[DEPTH-1];
   end

endmodule

// File: rtl/ge_row_feeder.sv
// Row feeder for the GF(2) systolic Gaussian-elimination array. Buffers one
// frame of rows, then streams it back-to-back into the N column inputs with
// column j delayed by j cycles, followed by N-1 zero cycles to drain the skew.
// Optional feature macro: GE_FEED_ERR_EN adds a sticky err_overflow output
// that flags a frame truncated because the buffer filled without row_last.
module ge_row_feeder
   import ge_pkg::*;
#(
   parameter int N        = 8,
   parameter int MAX_ROWS = 16
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         row_valid,
   output logic         row_ready,
   input  logic [N-1:0] row_data,
   input  logic         row_swap,
   input  logic         row_last,
   input  logic         mode_sel,
   output logic         mode,
   output logic [N-1:0] data_col,
   output logic [N-1:0] start_col,
   output logic [N-1:0] swap_col,
   output logic         busy,
   output logic         frame_done
`ifdef GE_FEED_ERR_EN
   ,
   output logic         err_overflow
`endif
);

   localparam int AW = index_width(MAX_ROWS);
   localparam int CW = $clog2(MAX_ROWS + 1);
   localparam int FW = index_width(N - 1);

   feed_state_t state, state_nxt;

   logic [N:0]    row_mem [MAX_ROWS];
   logic [N:0]    rd_row;
   logic [CW-1:0] row_cnt;
   logic [CW-1:0] rd_ptr;
   logic [FW-1:0] flush_cnt;
   logic          ready_en;
   logic          accept;
   logic          last_rd;
   logic          flush_end;
   logic          trunc;
   logic          streaming;

   assign accept    = row_valid & row_ready;
   assign streaming = (state == STREAM);
   assign last_rd   = (rd_ptr == row_cnt - CW'(1));
   assign flush_end = (flush_cnt == FW'(N - 2));
   assign rd_row    = row_mem[rd_ptr[AW-1:0]];
   assign busy      = (state != IDLE);

   // Input handshake: open in IDLE (once out of reset) and in LOAD while the buffer has room.
   always_comb begin
      row_ready = 1'b0;
      case (state)
         IDLE:    row_ready = ready_en;
         LOAD:    row_ready = (row_cnt < CW'(MAX_ROWS));
         default: row_ready = 1'b0;
      endcase
   end

   // Next-state logic; a full buffer without row_last is cut short and streamed as is.
   always_comb begin
      state_nxt = state;
      trunc     = 1'b0;
      case (state)
         IDLE, LOAD: begin
            if (accept) begin
               if (row_last || (row_cnt == CW'(MAX_ROWS - 1))) begin
                  state_nxt = STREAM;
                  trunc     = ~row_last;
               end else begin
                  state_nxt = LOAD;
               end
            end
         end
         STREAM: begin
            if (last_rd) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            if (flush_end) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus the handshake enable that keeps row_ready low through reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state    <= IDLE;
         ready_en <= 1'b0;
      end else begin
         state    <= state_nxt;
         ready_en <= 1'b1;
      end
   end

   // Write pointer / row count, read pointer and flush counter, all cleared when the frame ends.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         row_cnt   <= '0;
         rd_ptr    <= '0;
         flush_cnt <= '0;
      end else begin
         if (accept) begin
            row_cnt <= row_cnt + CW'(1);
         end
         if (streaming) begin
            rd_ptr <= rd_ptr + CW'(1);
         end
         if (state == FLUSH) begin
            if (flush_end) begin
               row_cnt   <= '0;
               rd_ptr    <= '0;
               flush_cnt <= '0;
            end else begin
               flush_cnt <= flush_cnt + FW'(1);
            end
         end
      end
   end

   // Frame buffer: each entry holds {swap, data} of one accepted row.
   always_ff @(posedge clk) begin
      if (accept) begin
         row_mem[row_cnt[AW-1:0]] <= {row_swap, row_data};
      end
   end

   // Array mode is captured on the first row of a frame and held until the next frame.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mode <= MODE_TRI;
      end else if (accept && (state == IDLE)) begin
         mode <= mode_sel;
      end
   end

   // One-cycle completion pulse in the cycle after the last flush cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= (state == FLUSH) && flush_end;
      end
   end

`ifdef GE_FEED_ERR_EN
   // Sticky truncation flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         err_overflow <= 1'b0;
      end else if (trunc) begin
         err_overflow <= 1'b1;
      end
   end
`else
   logic unused_trunc;
   assign unused_trunc = trunc;
`endif

   for (genvar j = 0; j < N; j++) begin : g_col
      logic [SKEW_W-1:0] head;
      logic [SKEW_W-1:0] tail;

      // Column j source: current buffered row while streaming, zeros otherwise.
      always_comb begin
         head = '0;
         if (streaming) begin
            head[SKEW_DATA]  = rd_row[j];
            head[SKEW_START] = (rd_ptr == '0);
            head[SKEW_SWAP]  = rd_row[N];
         end
      end

      ge_skew_line #(
         .DEPTH (j)
      ) u_skew (
         .clk   (clk),
         .rst_b (rst_b),
         .head  (head),
         .tail  (tail)
      );

      assign data_col[j]  = tail[SKEW_DATA];
      assign start_col[j] = tail[SKEW_START];
      assign swap_col[j]  = tail[SKEW_SWAP];
   end

endmodule

// File: tb/tb_ge_row_feeder.sv
// Testbench for ge_row_feeder. A driver offers rows and feeds accepted rows
// to a frame-level reference model, which pushes one expected record per
// cycle of the resulting skewed output window into a scoreboard queue. A
// separate monitor compares DUT outputs every cycle against that queue.
// Build with GE_FEED_ERR_EN defined to also check err_overflow.
module tb_ge_row_feeder;

   localparam int N        = 8;
   localparam int MAX_ROWS = 16;

   logic         clk       = 1'b0;
   logic         rst_b     = 1'b1;
   logic         row_valid = 1'b0;
   logic [N-1:0] row_data  = '0;
   logic         row_swap  = 1'b0;
   logic         row_last  = 1'b0;
   logic         mode_sel  = 1'b0;
   logic         row_ready;
   logic         mode;
   logic [N-1:0] data_col;
   logic [N-1:0] start_col;
   logic [N-1:0] swap_col;
   logic         busy;
   logic         frame_done;
`ifdef GE_FEED_ERR_EN
   logic         err_overflow;
`endif

   ge_row_feeder #(
      .N        (N),
      .MAX_ROWS (MAX_ROWS)
   ) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .row_data   (row_data),
      .row_swap   (row_swap),
      .row_last   (row_last),
      .mode_sel   (mode_sel),
      .mode       (mode),
      .data_col   (data_col),
      .start_col  (start_col),
      .swap_col   (swap_col),
      .busy       (busy),
      .frame_done (frame_done)
`ifdef GE_FEED_ERR_EN
      ,
      .err_overflow (err_overflow)
`endif
   );

   always #5 clk = ~clk;

   // Cycle index: the interval after the n-th rising edge is cycle n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int           cyc;
      logic [N-1:0] data;
      logic [N-1:0] start;
      logic [N-1:0] swap;
      logic         done;
      logic         busy;
      logic         ready;
      logic         mode;
   } exp_t;

   exp_t         sbq[$];
   exp_t         mon_e;
   logic [N-1:0] frame_data[$];
   logic         frame_swap[$];
   logic         frame_mode = 1'b0;
   int           err_from_cyc = -1;
   int           tests_run = 0;
   int           tests_failed = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   // Expected behaviour of a complete frame of R rows streaming from cycle s.
   function automatic void pushWindow(input int s);
      int r = frame_data.size();
      for (int t = 0; t < r + N; t++) begin
         exp_t e;
         e.cyc   = s + t;
         e.data  = '0;
         e.start = '0;
         e.swap  = '0;
         for (int j = 0; j < N; j++) begin
            int k = t - j;
            if (k >= 0 && k < r) begin
               e.data[j]  = frame_data[k][j];
               e.swap[j]  = frame_swap[k];
               e.start[j] = (k == 0);
            end
         end
         e.done  = (t == r + N - 1);
         e.busy  = !e.done;
         e.ready = e.done;
         e.mode  = frame_mode;
         sbq.push_back(e);
      end
   endfunction

   // Reference model for one accepted row; called during cycle n, edge n+1 accepts it.
   function automatic void modelAccept(input logic [N-1:0] d, input logic sw, input logic last,
                                       input logic ms);
      if (frame_data.size() == 0) frame_mode = ms;
      frame_data.push_back(d);
      frame_swap.push_back(sw);
      if (last || frame_data.size() == MAX_ROWS) begin
         if (!last && err_from_cyc < 0) err_from_cyc = cyc + 1;
         pushWindow(cyc + 1);
         frame_data.delete();
         frame_swap.delete();
      end
   endfunction

   // Monitor: every falling edge, compare against the scoreboard or against idle zeros.
   always @(negedge clk) begin
      if (!rst_b) begin
         checkOutput("reset_outputs",
                     64'({data_col, start_col, swap_col, frame_done, busy, row_ready, mode}), 64'd0);
      end else if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
         mon_e = sbq.pop_front();
         checkOutput("data_col", 64'(data_col), 64'(mon_e.data));
         checkOutput("start_col", 64'(start_col), 64'(mon_e.start));
         checkOutput("swap_col", 64'(swap_col), 64'(mon_e.swap));
         checkOutput("done_busy_ready_mode", 64'({frame_done, busy, row_ready, mode}),
                     64'({mon_e.done, mon_e.busy, mon_e.ready, mon_e.mode}));
      end else if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
         mon_e = sbq.pop_front();
         checkOutput("scoreboard_stale", 64'(mon_e.cyc), 64'(cyc));
      end else begin
         checkOutput("idle_zero", 64'({data_col, start_col, swap_col, frame_done}), 64'd0);
      end
`ifdef GE_FEED_ERR_EN
      checkOutput("err_overflow", 64'(err_overflow),
                  64'(rst_b && err_from_cyc >= 0 && cyc >= err_from_cyc));
`endif
   end

   // Offer one row after a gap and hold it until accepted (bounded wait).
   task automatic applyStimulus(input logic [N-1:0] d, input logic sw, input logic last,
                                input logic ms, input int gap);
      int   waited = 0;
      logic accepted = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      row_valid = 1'b1;
      row_data  = d;
      row_swap  = sw;
      row_last  = last;
      mode_sel  = ms;
      while (!accepted) begin
         @(negedge clk);
         if (row_ready && rst_b) begin
            modelAccept(d, sw, last, ms);
            accepted = 1'b1;
         end
         @(posedge clk);
         #1;
         if (!accepted) begin
            waited++;
            if (waited > 300) begin
               checkOutput("row_accept_timeout", 64'd0, 64'd1);
               break;
            end
         end
      end
      row_valid = 1'b0;
      row_last  = 1'b0;
      row_swap  = 1'b0;
      row_data  = '0;
   endtask

   task automatic doReset(input int cycles);
      rst_b = 1'b0;
      sbq.delete();
      frame_data.delete();
      frame_swap.delete();
      err_from_cyc = -1;
      row_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst_b = 1'b1;
   endtask

   task automatic randomFrame(input int len, input logic force_no_last);
      logic ms = 1'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) begin
         applyStimulus(N'($urandom), ($urandom_range(0, 3) == 0),
                       (i == len - 1) && !force_no_last,
                       (i == 0) ? ms : 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
   endtask

   initial begin
      int drain;
      #1;
      doReset(3);
      @(posedge clk);
      #1;

      // Three-row frame in triangularization mode.
      applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(8'h42, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(8'h24, 1'b0, 1'b1, 1'b0, 0);

      // Single row with row_last straight from IDLE, systemization mode.
      applyStimulus(8'hFF, 1'b0, 1'b1, 1'b1, 0);

      // Swap flag on row 1 only.
      applyStimulus(8'h0F, 1'b0, 1'b0, 1'b0, 0);
      applyStimulus(8'hF0, 1'b1, 1'b0, 1'b1, 1);
      applyStimulus(8'h3C, 1'b0, 1'b1, 1'b1, 0);

      // Exactly MAX_ROWS rows with row_last on the last one.
      randomFrame(MAX_ROWS, 1'b0);

      // MAX_ROWS+1 rows without row_last: truncation, 17th row starts a new frame.
      randomFrame(MAX_ROWS + 1, 1'b1);
      applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 0);

      // Reset during STREAM discards the frame.
      randomFrame(5, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      doReset(2);
      @(posedge clk);
      #1;

      // Normal operation after reset, then randomized frames.
      applyStimulus(8'h5A, 1'b0, 1'b1, 1'b1, 0);
      for (int f = 0; f < 20; f++) begin
         randomFrame($urandom_range(1, MAX_ROWS), 1'b0);
      end

      drain = 0;
      while (sbq.size() > 0 && drain < 300) begin
         @(posedge clk);
         drain++;
      end
      if (sbq.size() > 0) checkOutput("scoreboard_drain", 64'(sbq.size()), 64'd0);
      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
